// File: rtl/regfile_reader_pkg.sv
// regfile_reader_pkg: constants and types shared by the register-file
// reader, the register file and decode.
//   CoreDataWidth / CoreNumRegs / CoreAddrWidth : register-file geometry
//   reg_idx_t : register index type
//   state_t   : reader FSM states
package regfile_reader_pkg;

    localparam int CoreDataWidth = 16;
    localparam int CoreNumRegs   = 16;
    localparam int CoreAddrWidth = $clog2(CoreNumRegs);

    typedef logic [CoreAddrWidth-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/regfile_reader_if.sv
// regfile_reader_if: valid/ready word stream produced by the register-file
// reader.
//   out_valid : out_data/out_addr/out_last are valid
//   out_ready : sink accepts the word
//   out_data  : register value
//   out_addr  : register index of out_data
//   out_last  : final word of the requested range
// master = reader side, slave = sink side.
interface regfile_reader_if
    import regfile_reader_pkg::*;
#(
    parameter int DataWidth = CoreDataWidth,
    parameter int AddrWidth = CoreAddrWidth
);

    logic                 out_valid;
    logic                 out_ready;
    logic [DataWidth-1:0] out_data;
    logic [AddrWidth-1:0] out_addr;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: streams a contiguous (wrapping) range of registers out of
// the core register file over a valid/ready stream.
//   clk, rst       : clock, synchronous active-high reset
//   i_start        : request a dump (sampled only in IDLE)
//   i_first_addr   : first register index (sampled with i_start)
//   i_last_addr    : last register index (sampled with i_start)
//   i_abort        : cancel an in-progress dump
//   o_rf_addr      : register-file read address (always the load pointer)
//   i_rf_data      : register-file read data, combinational from o_rf_addr
//   bus            : output word stream (master side)
//   o_busy         : high in any state other than IDLE
//   o_done         : one-cycle pulse after the final handshake
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int DataWidth = CoreDataWidth,
    parameter int NumRegs   = CoreNumRegs,
    parameter int AddrWidth = $clog2(NumRegs)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [AddrWidth-1:0] i_first_addr,
    input  logic [AddrWidth-1:0] i_last_addr,
    input  logic                 i_abort,
    output logic [AddrWidth-1:0] o_rf_addr,
    input  logic [DataWidth-1:0] i_rf_data,
    regfile_reader_if.master     bus,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t               r_state;
    state_t               w_next_state;
    logic [AddrWidth-1:0] r_ptr;
    // One bit wider than an index so a full-file dump (NumRegs words) fits.
    logic [AddrWidth:0]   r_remaining;
    logic                 r_out_valid;
    logic [DataWidth-1:0] r_out_data;
    logic [AddrWidth-1:0] r_out_addr;
    logic                 r_out_last;
    logic                 r_done;

    logic                 w_fire;
    logic [AddrWidth-1:0] w_span;
    logic [AddrWidth:0]   w_count;

    // Span wraps modulo NumRegs, so count is always 1..NumRegs.
    assign w_span  = i_last_addr - i_first_addr;
    assign w_count = {1'b0, w_span} + (AddrWidth+1)'(1);
    assign w_fire  = r_out_valid & bus.out_ready;

    always_comb begin
        w_next_state = r_state;
        o_rf_addr    = r_ptr;
        o_busy       = (r_state != IDLE);
        case (r_state)
            IDLE: if (i_start) w_next_state = LOAD;
            LOAD: w_next_state = i_abort ? IDLE : SEND;
            SEND: begin
                if (i_abort)                  w_next_state = IDLE;
                else if (w_fire && r_out_last) w_next_state = DONE;
            end
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_ptr       <= i_first_addr;
                        r_remaining <= w_count;
                    end
                end
                // LOAD and a non-final fire in SEND share the word-load path,
                // which keeps the stream bubble-free under constant ready.
                LOAD, SEND: begin
                    if (i_abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (r_state == SEND && w_fire && r_out_last) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_state == LOAD || w_fire) begin
                        r_out_data  <= i_rf_data;
                        r_out_addr  <= r_ptr;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_remaining == (AddrWidth+1)'(1));
                        r_ptr       <= r_ptr + AddrWidth'(1);
                        r_remaining <= r_remaining - (AddrWidth+1)'(1);
                    end
                end
                DONE: r_done <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_last  = r_out_last;
    assign o_done        = r_done;

endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: scoreboard bench for regfile_reader with a behavioural
// register file beside it (posedge write, combinational read).
module tb_regfile_reader;
    import regfile_reader_pkg::*;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    regfile_reader_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    regfile_reader #(.DataWidth(DW), .NumRegs(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_first_addr (first_addr),
        .i_last_addr  (last_addr),
        .i_abort      (abort),
        .o_rf_addr    (rf_addr),
        .i_rf_data    (rf_data),
        .bus          (bus.master),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Register file: write lands on the edge, read is combinational.
    logic [DW-1:0] rf [NR];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
    assign rf_data = rf[rf_addr];

    // Reference contents of the register file and expected word stream.
    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } word_t;
    word_t         exp_q[$];
    logic [DW-1:0] mdl [NR];

    int total = 0;
    int bad   = 0;
    int fires = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    int          ready_mode = 0;
    int unsigned rcnt = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = (rcnt % 3 == 0);
                rcnt++;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every accepted word, checks stall
    // stability and that done follows the final handshake by one cycle.
    logic          prev_stall = 1'b0;
    logic          prev_last_fire = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    logic          hold_last;

    always @(negedge clk) begin : monitor
        logic  xfer;
        word_t w;
        xfer = bus.out_valid && bus.out_ready && !abort && !rst;
        if (!rst) check("done_timing", 32'(done), 32'(prev_last_fire));
        if (prev_stall && bus.out_valid && !rst) begin
            check("stall_data", 32'(bus.out_data), 32'(hold_data));
            check("stall_addr", 32'(bus.out_addr), 32'(hold_addr));
            check("stall_last", 32'(bus.out_last), 32'(hold_last));
        end
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.out_addr), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("word_data", 32'(bus.out_data), 32'(w.data));
                check("word_addr", 32'(bus.out_addr), 32'(w.addr));
                check("word_last", 32'(bus.out_last), 32'(w.last));
            end
            fires <= fires + 1;
        end
        prev_last_fire <= xfer && bus.out_last;
        prev_stall     <= bus.out_valid && !bus.out_ready && !rst;
        hold_data      <= bus.out_data;
        hold_addr      <= bus.out_addr;
        hold_last      <= bus.out_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        mdl[a]  = d;
    endtask

    // Expected words for a dump of first..last (modulo NR), up to maxw words.
    task automatic push_dump(input int f, input int l, input int maxw);
        int n;
        int idx;
        n = ((l - f) % NR + NR) % NR + 1;
        for (int k = 0; k < n && k < maxw; k++) begin
            idx = (f + k) % NR;
            exp_q.push_back('{mdl[idx], AW'(idx), (k == n - 1)});
        end
    endtask

    task automatic start_dump(input int f, input int l, input int maxw);
        push_dump(f, l, maxw);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_data"},  32'(bus.out_data),  32'd0);
        check({name, "_addr"},  32'(bus.out_addr),  32'd0);
        check({name, "_last"},  32'(bus.out_last),  32'd0);
        check({name, "_busy"},  32'(busy),          32'd0);
        check({name, "_done"},  32'(done),          32'd0);
        check({name, "_rfaddr"}, 32'(rf_addr),      32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [DW-1:0] old3;
        int            n;
        int            base;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        first_addr = '0;
        last_addr  = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NR; i++) rf_write(i, 16'hA000 + 16'(i));

        // Full dump with latency check.
        ready_mode = 0;
        start_dump(0, 15, NR);
        check("lat_load_valid", 32'(bus.out_valid), 32'd0);
        check("lat_load_busy", 32'(busy), 32'd1);
        tick();
        check("lat_send_valid", 32'(bus.out_valid), 32'd1);
        wait_idle("full");

        // Wrap and single word.
        start_dump(14, 1, NR);
        wait_idle("wrap");
        start_dump(5, 5, NR);
        wait_idle("single");

        // Backpressure.
        ready_mode = 1;
        start_dump(3, 10, NR);
        wait_idle("bp");

        // Abort on the third SEND cycle, together with a fire.
        ready_mode = 0;
        start_dump(0, 7, 2);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        start_dump(0, 2, NR);
        wait_idle("post_abort");

        // Reset mid-dump.
        start_dump(0, 15, NR);
        base = fires;
        n = 0;
        while (fires < base + 4 && n < 100) begin
            tick();
            n++;
        end
        check("rst_progress", 32'(fires >= base + 4), 32'd1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        check_zero_outputs("mid_rst");

        // Start pulsed while busy must not disturb the running range.
        ready_mode = 1;
        start_dump(2, 6, NR);
        tick();
        first_addr = AW'(9);
        last_addr  = AW'(12);
        start      = 1'b1;
        repeat (3) tick();
        start      = 1'b0;
        wait_idle("start_busy");

        // Coherency: write on the load cycle of index 3 returns the old value.
        ready_mode = 0;
        old3 = mdl[3];
        start_dump(0, 5, NR);
        n = 0;
        while (rf_addr != AW'(3) && n < 50) begin
            tick();
            n++;
        end
        rf_write(3, 16'h1234);
        wait_idle("coh_same_cycle");
        rf_write(3, old3);
        // A write landing before the load is seen by the dump.
        mdl[3] = 16'h1234;
        start_dump(0, 5, NR);
        n = 0;
        while (rf_addr != AW'(1) && n < 50) begin
            tick();
            n++;
        end
        rf_write(3, 16'h1234);
        wait_idle("coh_early");

        // Randomized dumps with random contents and sink behaviour.
        for (int r = 0; r < 10; r++) begin
            ready_mode = 2;
            rf_write($urandom_range(0, NR - 1), 16'($urandom));
            rf_write($urandom_range(0, NR - 1), 16'($urandom));
            start_dump($urandom_range(0, NR - 1), $urandom_range(0, NR - 1), NR);
            wait_idle("random");
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
